// File: rtl/messbauer_channel_decoder.sv
// Decodes start/channel pulses into a channel index and counts discriminator-qualified events per channel.
// Define MESSBAUER_DECODER_SYNC_EN to add a 2-flop synchronizer on every input (latency 3 instead of 1).
module messbauer_channel_decoder #(
    parameter int CHANNEL_NUMBER = 512,
    parameter int CHANNEL_WIDTH  = 9,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     start,
    input  logic                     channel,
    input  logic                     lower_threshold,
    input  logic                     upper_threshold,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic [COUNT_WIDTH-1:0]   out_count,
    output logic                     frame_done,
    output logic                     sync_error,
    output logic                     overflow
);

    typedef enum logic {S_IDLE, S_ACQUIRE} state_t;

    localparam logic [CHANNEL_WIDTH-1:0] LAST_CH = CHANNEL_WIDTH'(CHANNEL_NUMBER - 1);

    // Bit order: [3] start, [2] channel, [1] lower, [0] upper
    logic [3:0] w_in;
    logic [3:0] w_stage_in;
    logic [3:0] r_q;
    logic [3:1] r_d;

    assign w_in = {start, channel, lower_threshold, upper_threshold};

`ifdef MESSBAUER_DECODER_SYNC_EN
    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_in;
            r_sync <= r_meta;
        end
    end

    assign w_stage_in = r_sync;
`else
    assign w_stage_in = w_in;
`endif

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_q <= '0;
            r_d <= '0;
        end else begin
            r_q <= w_stage_in;
            r_d <= r_q[3:1];
        end
    end

    logic w_st_rise, w_ch_rise, w_lo_rise, w_lo_fall, w_up;
    assign w_st_rise = r_q[3] & ~r_d[3];
    assign w_ch_rise = r_q[2] & ~r_d[2];
    assign w_lo_rise = r_q[1] & ~r_d[1];
    assign w_lo_fall = ~r_q[1] & r_d[1];
    assign w_up      = r_q[0];

    // Event qualifier: a lower pulse counts only if upper never fired inside it
    logic r_win, r_upper_seen, w_event;
    assign w_event = w_lo_fall & r_win & ~r_upper_seen;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_win        <= 1'b0;
            r_upper_seen <= 1'b0;
        end else if (w_lo_rise) begin
            r_win        <= 1'b1;
            r_upper_seen <= w_up;
        end else if (w_lo_fall) begin
            r_win        <= 1'b0;
        end else if (r_win && w_up) begin
            r_upper_seen <= 1'b1;
        end
    end

    state_t                   r_state, w_state_nxt;
    logic [CHANNEL_WIDTH-1:0] r_index, w_index_nxt;
    logic [COUNT_WIDTH-1:0]   r_count, w_count_nxt;
    logic                     w_fire, w_done, w_sync_set;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_count_nxt = r_count;
        w_fire      = 1'b0;
        w_done      = 1'b0;
        w_sync_set  = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_st_rise) begin
                w_index_nxt = '0;
                w_count_nxt = '0;
                w_state_nxt = S_ACQUIRE;
            end
        end else begin
            // Start outranks channel: the partial channel is discarded without a record
            if (w_st_rise) begin
                w_sync_set  = 1'b1;
                w_index_nxt = '0;
                w_count_nxt = '0;
            end else if (w_ch_rise) begin
                w_fire = 1'b1;
                if (r_index == LAST_CH) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_index_nxt = '0;
                    w_count_nxt = '0;
                end else begin
                    w_index_nxt = r_index + CHANNEL_WIDTH'(1);
                    w_count_nxt = w_event ? COUNT_WIDTH'(1) : '0;
                end
            end else if (w_event && (r_count != '1)) begin
                w_count_nxt = r_count + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_count   <= '0;
            frame_done  <= 1'b0;
            sync_error  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= w_done;
            if (w_sync_set)
                sync_error <= 1'b1;
            if (w_fire) begin
                if (!out_valid || out_ready) begin
                    out_valid   <= 1'b1;
                    out_channel <= r_index;
                    out_count   <= r_count;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_messbauer_channel_decoder.sv
// Directed + randomized bench for messbauer_channel_decoder (4 channels, 4-bit counter).
module tb_messbauer_channel_decoder;

    localparam int CN  = 4;
    localparam int CHW = 2;
    localparam int CW  = 4;

    logic           aclk = 1'b0;
    logic           areset_n = 1'b0;
    logic           start = 1'b0, channel = 1'b0;
    logic           lower_threshold = 1'b0, upper_threshold = 1'b0;
    logic           out_ready = 1'b1;
    logic           out_valid, frame_done, sync_error, overflow;
    logic [CHW-1:0] out_channel;
    logic [CW-1:0]  out_count;

    messbauer_channel_decoder #(
        .CHANNEL_NUMBER(CN), .CHANNEL_WIDTH(CHW), .COUNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .areset_n(areset_n), .start(start), .channel(channel),
        .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
        .out_ready(out_ready), .out_valid(out_valid), .out_channel(out_channel),
        .out_count(out_count), .frame_done(frame_done), .sync_error(sync_error),
        .overflow(overflow)
    );

    always #10 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int got_ch[$];
    int got_cnt[$];
    int fd_ch[$];

    // Records accepted by the downstream side, plus channel seen with each frame_done pulse
    always @(negedge aclk) begin
        if (out_valid && out_ready) begin
            got_ch.push_back(int'(out_channel));
            got_cnt.push_back(int'(out_count));
        end
        if (frame_done)
            fd_ch.push_back(out_valid ? int'(out_channel) : -1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic clear_q();
        got_ch.delete();
        got_cnt.delete();
        fd_ch.delete();
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        tick(2);
        areset_n = 1'b1;
        tick(2);
        clear_q();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(2); start = 1'b0; tick(2);
    endtask

    task automatic pulse_channel();
        channel = 1'b1; tick(2); channel = 1'b0; tick(2);
    endtask

    // One lower pulse; with_upper puts a 1-cycle upper pulse strictly inside it
    task automatic ev(input bit with_upper);
        lower_threshold = 1'b1;
        tick(1);
        if (with_upper) begin
            upper_threshold = 1'b1; tick(1);
            upper_threshold = 1'b0; tick(2);
        end else begin
            tick(1);
        end
        lower_threshold = 1'b0;
        tick(2);
    endtask

    task automatic check_rec(input string tag, input int idx, input int ch, input int cnt);
        if (got_ch.size() > idx) begin
            chk({tag, "_ch"}, got_ch[idx], ch);
            chk({tag, "_cnt"}, got_cnt[idx], cnt);
        end else begin
            chk({tag, "_missing"}, got_ch.size(), idx + 1);
        end
    endtask

    function automatic int sat(input int n);
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
    endfunction

    // Sends a full frame and checks the records against the saturating-count model
    task automatic frame_check(input string tag, input int cnts[CN]);
        clear_q();
        pulse_start();
        for (int c = 0; c < CN; c++) begin
            for (int e = 0; e < cnts[c]; e++) ev(1'b0);
            pulse_channel();
        end
        tick(6);
        chk({tag, "_nrec"}, got_ch.size(), CN);
        for (int c = 0; c < CN; c++)
            check_rec($sformatf("%s_rec%0d", tag, c), c, c, sat(cnts[c]));
        chk({tag, "_fd_n"}, fd_ch.size(), 1);
        if (fd_ch.size() > 0) chk({tag, "_fd_ch"}, fd_ch[0], CN - 1);
        chk({tag, "_sync"}, int'(sync_error), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    initial begin
        int cnts[CN];

        // Reset state, held in reset
        #5;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_chan", int'(out_channel), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_sync", int'(sync_error), 0);
        chk("rst_ovf", int'(overflow), 0);
        tick(2);
        areset_n = 1'b1;
        tick(2);

        // Basic frame 0,2,1,3, then IDLE ignores channel pulses
        cnts = '{0, 2, 1, 3};
        frame_check("frame", cnts);
        ev(1'b0);
        pulse_channel();
        tick(6);
        chk("idle_norec", got_ch.size(), CN);

        // Discriminator rejection of upper-qualified pulse
        do_reset();
        pulse_start();
        ev(1'b1);
        ev(1'b0);
        pulse_channel();
        tick(6);
        chk("disc_nrec", got_ch.size(), 1);
        check_rec("disc", 0, 0, 1);

        // Mid-frame start after two channel pulses
        do_reset();
        pulse_start();
        pulse_channel();
        pulse_channel();
        ev(1'b0);
        ev(1'b0);
        pulse_start();
        tick(6);
        chk("mid_sync", int'(sync_error), 1);
        chk("mid_nopartial", got_ch.size(), 2);
        ev(1'b0);
        pulse_channel();
        tick(6);
        check_rec("mid_next", 2, 0, 1);
        chk("mid_ovf", int'(overflow), 0);

        // Backpressure: second record dropped, first held
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        ev(1'b0);
        ev(1'b0);
        pulse_channel();
        ev(1'b0);
        pulse_channel();
        tick(6);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_chan", int'(out_channel), 0);
        chk("bp_count", int'(out_count), 2);
        chk("bp_ovf", int'(overflow), 1);
        chk("bp_none", got_ch.size(), 0);
        out_ready = 1'b1;
        tick(5);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_n", got_ch.size(), 1);
        check_rec("bp_release", 0, 0, 2);
        chk("bp_ovf_sticky", int'(overflow), 1);

        // Saturation plus random frames
        do_reset();
        cnts[0] = 20;
        for (int c = 1; c < CN; c++) cnts[c] = $urandom_range(0, 20);
        frame_check("sat", cnts);
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < CN; c++) cnts[c] = $urandom_range(0, 20);
            frame_check($sformatf("rand%0d", f), cnts);
        end

        // Reset mid-frame with held record and both flags set
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        ev(1'b0);
        ev(1'b0);
        pulse_channel();
        ev(1'b0);
        ev(1'b0);
        ev(1'b0);
        pulse_start();
        pulse_channel();
        ev(1'b0);
        tick(6);
        chk("mrst_pre_valid", int'(out_valid), 1);
        chk("mrst_pre_sync", int'(sync_error), 1);
        chk("mrst_pre_ovf", int'(overflow), 1);
        areset_n = 1'b0;
        #1;
        chk("mrst_valid", int'(out_valid), 0);
        chk("mrst_chan", int'(out_channel), 0);
        chk("mrst_count", int'(out_count), 0);
        chk("mrst_fd", int'(frame_done), 0);
        chk("mrst_sync", int'(sync_error), 0);
        chk("mrst_ovf", int'(overflow), 0);
        tick(2);
        areset_n = 1'b1;
        out_ready = 1'b1;
        tick(2);
        clear_q();
        pulse_channel();
        pulse_channel();
        tick(6);
        chk("mrst_ignored", got_ch.size(), 0);
        chk("mrst_ignored_valid", int'(out_valid), 0);
        pulse_start();
        ev(1'b0);
        pulse_channel();
        tick(6);
        check_rec("mrst_recover", 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/messbauer_channel_decoder.md
# messbauer_channel_decoder

Receive-side counterpart of the Mossbauer start/channel generator and differential-discriminator signal source. Decodes the `start`/`channel` pulse train into a running channel index and counts discriminator-qualified gamma events within each channel window. Emits one `{channel, count}` record per closed channel over a valid/ready interface, for a downstream spectrum memory or host link. Sits in the test environment as the loopback checker for the generator outputs, and later in the real spectrometer front end.

## Interface
- `CHANNEL_NUMBER`, 512: channels per frame (start to last channel pulse).
- `CHANNEL_WIDTH`, 9: width of channel index; must satisfy 2^CHANNEL_WIDTH >= CHANNEL_NUMBER.
- `COUNT_WIDTH`, 16: width of per-channel event counter.

- `aclk` in 1: single system clock (50 MHz).
- `areset_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame start pulse (level, edge-detected).
- `channel` in 1: channel advance pulse (level, edge-detected).
- `lower_threshold` in 1: discriminator lower comparator output.
- `upper_threshold` in 1: discriminator upper comparator output.
- `out_ready` in 1: downstream accepts record.
- `out_valid` out 1: record available.
- `out_channel` out CHANNEL_WIDTH: index of closed channel.
- `out_count` out COUNT_WIDTH: events counted in that channel.
- `frame_done` out 1: one-cycle pulse when last channel record is produced.
- `sync_error` out 1: sticky; start seen mid-frame.
- `overflow` out 1: sticky; record dropped because output register occupied.

## Operation
- All inputs pass through the input stage (see Configuration), then rising-edge detect. Only the resulting one-cycle edge strobes drive logic; `lower_threshold` also needs a falling-edge strobe.
- Event qualifier:
  - Rising `lower_threshold` opens a window and clears the `upper_seen` flag.
  - Any cycle with `upper_threshold` high while the window is open sets `upper_seen`.
  - Falling `lower_threshold` closes the window. If `upper_seen` is clear, this is one event.
- FSM IDLE:
  - Ignores channel strobes and events.
  - A start strobe sets index=0, count=0 and moves to ACQUIRE.
- FSM ACQUIRE:
  - An event increments count, saturating at all-ones.
  - A channel strobe closes the current channel: it produces record `{index, count}`.
    - If index == CHANNEL_NUMBER-1: pulse `frame_done` and return to IDLE.
    - Otherwise: index+1, count=0.
  - A start strobe is a mid-frame start: set `sync_error`, discard the partial channel (no record), then index=0, count=0, stay in ACQUIRE.
- Simultaneous events:
  - Channel strobe + event in the same cycle: the event counts into the new channel (count=1). On the last channel it is discarded.
  - Start + channel in the same cycle: start wins and no record is produced.
- Output register (single entry):
  - A record loads when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in that cycle.
  - Otherwise the new record is dropped, `overflow` is set, and the held record is unchanged.
  - `out_valid` drops after a cycle with `out_ready`=1 unless a new record loads.
- `sync_error` and `overflow` clear only on reset.

## Timing
- Reset values:
  - `out_valid`=0, `out_channel`=0, `out_count`=0, `frame_done`=0, `sync_error`=0, `overflow`=0.
  - FSM in IDLE, index=0, count=0, all edge-detect history=0.
- Input latency L: L=3 clocks with SYNC, L=1 without. L is measured from the first clock edge sampling an input high to the edge at which state updates.
- A record appears (`out_valid`=1) on the same edge the index advances. `frame_done` is asserted on that same edge for one cycle.
- Inputs must be held high or low for at least 2 clocks to be seen as distinct edges.
- Reset mid-frame: all state is lost immediately and no record is produced. Outputs take reset values asynchronously.

## Configuration
- `MESSBAUER_DECODER_SYNC_EN` defined: every input gets a 2-flop synchronizer before edge detection, so L=3. Use this for external, asynchronous signals.
- `MESSBAUER_DECODER_SYNC_EN` not defined: inputs are registered once into edge detection, so L=1. Use this only when the source is clocked by `aclk`, as in the test environment.

## Test plan
- Frame, CHANNEL_NUMBER=4, `out_ready`=1: send start, then per channel 0,2,1,3 qualified events, then 4 channel pulses. Required: records (0,0),(1,2),(2,1),(3,3), `frame_done` with record 3, return to IDLE, flags 0.
- Discriminator: lower pulse with upper high for 1 cycle inside it, then a clean lower pulse, then channel. Required: count=1.
- Mid-frame start after 2 channel pulses. Required: `sync_error`=1, no record for the partial channel, next record is channel 0.
- Backpressure, `out_ready`=0 across 2 channel pulses. Required: first record held, `overflow`=1, second record dropped; `out_ready`=1 then releases the first record only.
- Saturation, COUNT_WIDTH=4: 20 events in one channel. Required: record count=15.
- Reset asserted mid-frame after channel 1 events. Required: all outputs 0 at once; channel pulses are ignored until the next start.
